// File: rtl/stepper_phase_decoder.sv
// Receive-side half-step decoder for the PIO stepper coil pattern: position, step/dir, lock and fault status.
// Optional feature macro STEPPER_DEC_FULLSTEP_EN: two-index jumps count as double steps instead of errors.
module stepper_phase_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int POS_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       phase_in,
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic             step,
  output logic             dir,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [2:0]       phase_idx
);

  localparam int CNT_W = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [POS_W-1:0] POS_TWO = POS_W'(2);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  logic [3:0]       sync1, sync2, filt_code, acc_code;
  logic             acc_valid;
  logic [CNT_W-1:0] stab_cnt;
  logic             accept;
  logic [1:0]       state, nxt_state;
  logic             code_ok;
  logic [2:0]       code_idx, delta, nxt_idx;
  logic             do_step, do_err, step_fwd, step_two;
  logic [POS_W-1:0] step_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      filt_code <= '0;
      stab_cnt  <= '0;
    end else begin
      sync1     <= phase_in;
      sync2     <= sync1;
      filt_code <= sync2;
      if (sync2 != filt_code)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + CNT_ONE;
    end
  end

  assign accept = (stab_cnt == CNT_MAX) && (!acc_valid || (filt_code != acc_code));

  // Acceptance bookkeeping belongs to the filter: clear does not touch it, so a code
  // accepted in the same cycle as clear is consumed and not re-accepted afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_valid <= 1'b0;
      acc_code  <= '0;
    end else if (accept) begin
      acc_valid <= 1'b1;
      acc_code  <= filt_code;
    end
  end

  always_comb begin
    code_ok  = 1'b1;
    code_idx = 3'd0;
    case (filt_code)
      4'b1001: code_idx = 3'd0;
      4'b0001: code_idx = 3'd1;
      4'b0011: code_idx = 3'd2;
      4'b0010: code_idx = 3'd3;
      4'b0110: code_idx = 3'd4;
      4'b0100: code_idx = 3'd5;
      4'b1100: code_idx = 3'd6;
      4'b1000: code_idx = 3'd7;
      default: code_ok  = 1'b0;
    endcase
  end

  assign delta = code_idx - phase_idx;

  always_comb begin
    nxt_state = state;
    nxt_idx   = phase_idx;
    do_step   = 1'b0;
    do_err    = 1'b0;
    step_fwd  = 1'b1;
    step_two  = 1'b0;
    if (accept) begin
      case (state)
        ST_LOCKED: begin
          if (!code_ok) begin
            nxt_state = ST_FAULT;
            do_err    = 1'b1;
          end else begin
            nxt_idx = code_idx;
            case (delta)
              3'd1: do_step = 1'b1;
              3'd7: begin
                do_step  = 1'b1;
                step_fwd = 1'b0;
              end
`ifdef STEPPER_DEC_FULLSTEP_EN
              3'd2: begin
                do_step  = 1'b1;
                step_two = 1'b1;
              end
              3'd6: begin
                do_step  = 1'b1;
                step_fwd = 1'b0;
                step_two = 1'b1;
              end
`endif
              default: do_err = 1'b1;
            endcase
          end
        end
        default: begin
          if (code_ok) begin
            nxt_state = ST_LOCKED;
            nxt_idx   = code_idx;
          end else begin
            nxt_state = ST_FAULT;
            do_err    = 1'b1;
          end
        end
      endcase
    end
  end

  assign step_mag = step_two ? POS_TWO : POS_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_UNLOCKED;
      position  <= '0;
      step      <= 1'b0;
      dir       <= 1'b1;
      err_pulse <= 1'b0;
      err_count <= '0;
      phase_idx <= '0;
    end else begin
      step      <= 1'b0;
      err_pulse <= 1'b0;
      if (clear) begin
        state     <= ST_UNLOCKED;
        position  <= '0;
        err_count <= '0;
      end else begin
        state     <= nxt_state;
        phase_idx <= nxt_idx;
        step      <= do_step;
        err_pulse <= do_err;
        if (do_step) begin
          dir      <= step_fwd;
          position <= step_fwd ? (position + step_mag) : (position - step_mag);
        end
        if (do_err && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign fault  = (state == ST_FAULT);

endmodule
